memory_access_unit: RTL

MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

---
 rtl/processor_pkg.sv | 13 +
 rtl/mem_timeout_ctr.sv | 31 +++
 rtl/memory_access_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/processor_pkg.sv
// Shared processor definitions: datapath width, watchdog default and the
// memory access FSM state encoding.
package processor_pkg;

    localparam int DATA_W         = 16;
    localparam int TIMEOUT_CYCLES = 64;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Watchdog for the memory access unit: counts BUSY cycles and flags expiry
// on the last allowed cycle. Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic busy,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (busy && !expired) begin
            count <= count + 1'b1;
        end
    end

    // Expiry is asserted during the final BUSY cycle so the FSM leaves BUSY
    // after exactly TIMEOUT_CYCLES cycles.
    assign expired = busy && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/memory_access_unit.sv
// Multicycle memory access unit: one outstanding read/write handshake with
// IR/MDR capture. Optional watchdog enabled by defining MEM_TIMEOUT_EN.
module memory_access_unit
    import processor_pkg::*;
#(
    parameter int DATA_W         = processor_pkg::DATA_W,
    parameter int TIMEOUT_CYCLES = processor_pkg::TIMEOUT_CYCLES
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IorD,
    input  logic              IRWrite,
    input  logic [DATA_W-1:0] PC,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] MDR,
    output logic [3:0]        Opcode,
    output logic              MemStall,
    output logic              MemError,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    mem_state_t state;
    logic       ir_target;
    logic       start;
    logic       expired;

    assign start  = (state == IDLE) && (MemRead ^ MemWrite);
    assign Opcode = IR[3:0];

`ifdef MEM_TIMEOUT_EN
    mem_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (CLK),
        .rst     (Reset),
        .clear   (start),
        .busy    (state == BUSY),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            IR        <= '0;
            MDR       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            MemStall  <= 1'b0;
            MemError  <= 1'b0;
            ir_target <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= BUSY;
                        mem_req   <= 1'b1;
                        MemStall  <= 1'b1;
                        mem_addr  <= IorD ? ALUOut : PC;
                        mem_we    <= MemWrite;
                        mem_wdata <= B;
                        ir_target <= IRWrite;
                    end else if (MemRead && MemWrite) begin
                        MemError <= 1'b1;
                    end
                end
                BUSY: begin
                    // Control inputs are deliberately not looked at here:
                    // the captured request stays stable until it completes.
                    if (mem_ack) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        MemStall <= 1'b0;
                        if (!mem_we) begin
                            if (ir_target) IR  <= mem_rdata;
                            else           MDR <= mem_rdata;
                        end
                    end else if (expired) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        MemStall <= 1'b0;
                        MemError <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
